// File: rtl/dec_scan_ctrl.sv
// Select-code sequencer for the 4-to-16 LED decoder: manual, up, down and ping-pong scans.
// All outputs registered (1-cycle latency from start/stop/man_sel); no backpressure, steps run at clk/DIV.
module dec_scan_ctrl #(
  parameter int DIV    = 50_000_000,
  parameter int SWEEPS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [3:0] man_sel,
  output logic [3:0] sel,
  output logic       busy,
  output logic       tick,
  output logic       wrap,
  output logic       done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, MAN, UP, DN, PP_UP, PP_DN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [7:0]    sweep_cnt, sweep_nxt, sweep_inc;
  logic [3:0]    sel_nxt;
  logic          busy_nxt, tick_nxt, wrap_nxt, done_nxt;
  logic          step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 4'd0;
      pre       <= '0;
      sweep_cnt <= 8'd0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      pre       <= pre_nxt;
      sweep_cnt <= sweep_nxt;
      busy      <= busy_nxt;
      tick      <= tick_nxt;
      wrap      <= wrap_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pre_nxt   = pre;
    sweep_nxt = sweep_cnt;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    step      = (pre == PRE_MAX);
    sweep_inc = (sweep_cnt == 8'hFF) ? sweep_cnt : sweep_cnt + 8'd1;

    case (state)
      IDLE: begin
        pre_nxt   = '0;
        sweep_nxt = 8'd0;
        if (start && !stop) begin
          case (mode)
            2'b00: state_nxt = MAN;
            2'b01: begin state_nxt = UP;    sel_nxt = 4'd0;  end
            2'b10: begin state_nxt = DN;    sel_nxt = 4'd15; end
            default: begin state_nxt = PP_UP; sel_nxt = 4'd0; end
          endcase
        end
      end
      MAN: begin
        if (stop) state_nxt = IDLE;
        else      sel_nxt   = man_sel;
      end
      default: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (!step) begin
          pre_nxt = pre + 1'b1;
        end else begin
          pre_nxt  = '0;
          tick_nxt = 1'b1;
          case (state)
            UP: begin
              sel_nxt  = sel + 4'd1;
              wrap_nxt = (sel == 4'd15);
            end
            DN: begin
              sel_nxt  = sel - 4'd1;
              wrap_nxt = (sel == 4'd0);
            end
            PP_UP: begin
              // the turnaround tick goes straight to 14 so 15 is shown only once per sweep
              if (sel == 4'd15) begin
                state_nxt = PP_DN;
                sel_nxt   = 4'd14;
              end else begin
                sel_nxt = sel + 4'd1;
              end
            end
            default: begin
              sel_nxt = sel - 4'd1;
              if (sel == 4'd1) begin
                wrap_nxt  = 1'b1;
                state_nxt = PP_UP;
              end
            end
          endcase
          if (wrap_nxt) begin
            sweep_nxt = sweep_inc;
            if (SWEEPS != 0 && int'(sweep_inc) == SWEEPS) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: directed scenarios then random start/stop/reset traffic,
// every cycle compared against a step-count model of the scan sequences.
module tb_dec_scan_ctrl;
  localparam int DIV    = 4;
  localparam int SWEEPS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] man_sel = 4'd0;
  logic [3:0] sel;
  logic       busy, tick, wrap, done;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DIV(DIV), .SWEEPS(SWEEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .man_sel(man_sel), .sel(sel), .busy(busy), .tick(tick), .wrap(wrap), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // model: a run is described by its mode, cycles since entry and steps taken
  bit         m_run = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int         m_cyc = 0, m_steps = 0, m_wraps = 0;
  logic [3:0] m_sel = 4'd0;
  logic       m_busy = 1'b0, m_tick = 1'b0, m_wrap = 1'b0, m_done = 1'b0;

  function automatic logic [3:0] pos(input logic [1:0] m, input int n);
    int k;
    case (m)
      2'b01:   k = n % 16;
      2'b10:   k = 15 - (n % 16);
      default: begin
        k = n % 30;
        if (k > 15) k = 30 - k;
      end
    endcase
    return 4'(k);
  endfunction

  function automatic int period(input logic [1:0] m);
    return (m == 2'b11) ? 30 : 16;
  endfunction

  task automatic model(input logic r, input logic s, input logic p,
                       input logic [1:0] m, input logic [3:0] ms);
    m_tick = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
    if (r) begin
      m_run = 1'b0; m_sel = 4'd0;
    end else if (!m_run) begin
      if (s && !p) begin
        m_run = 1'b1; m_mode = m; m_cyc = 0; m_steps = 0; m_wraps = 0;
        if (m != 2'b00) m_sel = pos(m, 0);
      end
    end else if (p) begin
      m_run = 1'b0;
    end else if (m_mode == 2'b00) begin
      m_sel = ms;
    end else begin
      m_cyc++;
      if (m_cyc % DIV == 0) begin
        m_tick = 1'b1;
        m_steps++;
        m_sel = pos(m_mode, m_steps);
        if (m_steps % period(m_mode) == 0) begin
          m_wrap = 1'b1;
          m_wraps++;
          if (SWEEPS != 0 && m_wraps == SWEEPS) begin
            m_done = 1'b1; m_run = 1'b0;
          end
        end
      end
    end
    m_busy = m_run;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p,
                     input logic [1:0] m, input logic [3:0] ms);
    rst = r; start = s; stop = p; mode = m; man_sel = ms;
    @(posedge clk);
    model(r, s, p, m, ms);
    #1;
    chk("sel",  {4'd0, sel}, {4'd0, m_sel});
    chk("busy", {7'd0, busy}, {7'd0, m_busy});
    chk("tick", {7'd0, tick}, {7'd0, m_tick});
    chk("wrap", {7'd0, wrap}, {7'd0, m_wrap});
    chk("done", {7'd0, done}, {7'd0, m_done});
  endtask

  initial begin
    logic       r, s, p;
    logic [1:0] m;
    logic [3:0] ms;

    cyc(1, 0, 0, 2'b00, 4'd0);
    cyc(1, 0, 0, 2'b00, 4'd0);
    chk("rst_sel", {4'd0, sel}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);

    // up-scan; mode flips mid-run must be ignored
    cyc(0, 1, 0, 2'b01, 4'd0);
    chk("up_start_sel", {4'd0, sel}, 8'd0);
    chk("up_start_busy", {7'd0, busy}, 8'd1);
    for (int i = 1; i <= 16 * DIV; i++) cyc(0, 0, 0, 2'b10, 4'd0);
    chk("up_wrap", {7'd0, wrap}, 8'd1);
    chk("up_wrap_sel", {4'd0, sel}, 8'd0);
    cyc(0, 0, 1, 2'b00, 4'd0);
    chk("up_stop_busy", {7'd0, busy}, 8'd0);

    // ping-pong with auto-stop after two sweeps
    cyc(0, 1, 0, 2'b11, 4'd0);
    for (int i = 1; i <= 60 * DIV; i++) cyc(0, 0, 0, 2'b00, 4'd0);
    chk("pp_done", {7'd0, done}, 8'd1);
    chk("pp_done_busy", {7'd0, busy}, 8'd0);
    chk("pp_done_sel", {4'd0, sel}, 8'd0);

    // manual pass-through
    cyc(0, 1, 0, 2'b00, 4'hA);
    cyc(0, 0, 0, 2'b00, 4'hA);
    chk("man_a", {4'd0, sel}, 8'h0A);
    cyc(0, 0, 0, 2'b00, 4'h3);
    chk("man_3", {4'd0, sel}, 8'h03);
    chk("man_tick", {7'd0, tick}, 8'd0);
    cyc(0, 0, 1, 2'b00, 4'h5);
    chk("man_stop_sel", {4'd0, sel}, 8'h03);

    // start and stop together from idle
    cyc(0, 1, 1, 2'b01, 4'd0);
    chk("ss_busy", {7'd0, busy}, 8'd0);
    chk("ss_sel", {4'd0, sel}, 8'h03);

    // down-scan interrupted by reset, then restarted
    cyc(0, 1, 0, 2'b10, 4'd0);
    chk("dn_start_sel", {4'd0, sel}, 8'd15);
    for (int i = 1; i <= 8 * DIV; i++) cyc(0, 0, 0, 2'b01, 4'd0);
    chk("dn_sel7", {4'd0, sel}, 8'd7);
    cyc(1, 0, 0, 2'b10, 4'd0);
    chk("dn_rst_sel", {4'd0, sel}, 8'd0);
    chk("dn_rst_busy", {7'd0, busy}, 8'd0);
    cyc(0, 1, 0, 2'b10, 4'd0);
    for (int i = 1; i < DIV; i++) cyc(0, 0, 0, 2'b10, 4'd0);
    chk("dn_restart_notick", {7'd0, tick}, 8'd0);
    cyc(0, 0, 0, 2'b10, 4'd0);
    chk("dn_restart_tick", {7'd0, tick}, 8'd1);
    chk("dn_restart_sel", {4'd0, sel}, 8'd14);
    cyc(0, 0, 1, 2'b00, 4'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 29) == 0);
      p  = ($urandom_range(0, 299) == 0);
      m  = 2'($urandom_range(0, 3));
      ms = 4'($urandom_range(0, 15));
      cyc(r, s, p, m, ms);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
